// File: rtl/ri_control_unit.sv
// ---------------------------------------------------------------------------
// ri_control_unit
//
// Multi-cycle control unit for the R/I-type MIPS subset. Captures the
// instruction word from the program counter / ROM stage, decodes it, and
// sequences one instruction every four clocks (FETCH, DECODE, EXEC, WB).
//
// Ports
//   clka        in   rising-edge clock
//   rsta        in   asynchronous active-high reset
//   run         in   sampled in FETCH only; low parks the FSM in FETCH
//   instr[31:0] in   instruction word from the ROM stage
//   ir[31:0]    out  latched instruction register
//   state[1:0]  out  FETCH=0, DECODE=1, EXEC=2, WB=3
//   rs_addr     out  ir[25:21]
//   rt_addr     out  ir[20:16]
//   wb_addr     out  rd for R-type, rt for I-type
//   shamt       out  ir[10:6]
//   imm_ext     out  extended immediate (sign/zero/upper, 0 for R-type)
//   alu_op[3:0] out  ADD..LUI operation select
//   alu_src_imm out  1 selects imm_ext as ALU operand B
//   reg_we      out  register-file write strobe, asserted in WB
//   pc_en       out  one-cycle PC advance request, asserted in DECODE
//   illegal     out  sticky unsupported-instruction flag
//   instr_cnt   out  retired-instruction counter (wraps)
//
// All outputs are registers, so the asynchronous reset clears any pending
// strobe immediately.
// ---------------------------------------------------------------------------
module ri_control_unit (
  input  logic        clka,
  input  logic        rsta,
  input  logic        run,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  output logic [1:0]  state,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wb_addr,
  output logic [4:0]  shamt,
  output logic [31:0] imm_ext,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        pc_en,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  // FSM encoding is visible on the state port, so values are fixed.
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  // ALU operation codes.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type function codes.
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm_ext;
    logic [4:0]  wb_addr;
    logic        legal;
  } dec_t;

  // Pure decode of one instruction word. Unsupported words collapse to a
  // harmless ADD with register operands and are flagged not legal.
  function automatic dec_t decode_instr(input logic [31:0] w);
    dec_t d;
    d.alu_op      = ALU_ADD;
    d.alu_src_imm = 1'b0;
    d.imm_ext     = 32'h0000_0000;
    d.wb_addr     = w[20:16];
    d.legal       = 1'b1;
    case (w[31:26])
      OP_RTYPE: begin
        d.wb_addr = w[15:11];
        case (w[5:0])
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_XOR:  d.alu_op = ALU_XOR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          FN_SLL:  d.alu_op = ALU_SLL;
          FN_SRL:  d.alu_op = ALU_SRL;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.alu_op      = ALU_ADD;
        d.alu_src_imm = 1'b1;
        d.imm_ext     = {{16{w[15]}}, w[15:0]};
      end
      OP_SLTI: begin
        d.alu_op      = ALU_SLT;
        d.alu_src_imm = 1'b1;
        d.imm_ext     = {{16{w[15]}}, w[15:0]};
      end
      OP_ANDI: begin
        d.alu_op      = ALU_AND;
        d.alu_src_imm = 1'b1;
        d.imm_ext     = {16'h0000, w[15:0]};
      end
      OP_ORI: begin
        d.alu_op      = ALU_OR;
        d.alu_src_imm = 1'b1;
        d.imm_ext     = {16'h0000, w[15:0]};
      end
      OP_XORI: begin
        d.alu_op      = ALU_XOR;
        d.alu_src_imm = 1'b1;
        d.imm_ext     = {16'h0000, w[15:0]};
      end
      OP_LUI: begin
        d.alu_op      = ALU_LUI;
        d.alu_src_imm = 1'b1;
        d.imm_ext     = {w[15:0], 16'h0000};
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) begin
      d.alu_op      = ALU_ADD;
      d.alu_src_imm = 1'b0;
      d.imm_ext     = 32'h0000_0000;
    end else begin
      d.alu_op      = d.alu_op;
    end
    return d;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  dec_t        dec_s;
  logic [31:0] ir_r;
  logic [4:0]  rs_addr_r;
  logic [4:0]  rt_addr_r;
  logic [4:0]  wb_addr_r;
  logic [4:0]  shamt_r;
  logic [31:0] imm_ext_r;
  logic [3:0]  alu_op_r;
  logic        alu_src_imm_r;
  logic        legal_r;
  logic        reg_we_r;
  logic        pc_en_r;
  logic        illegal_r;
  logic [31:0] instr_cnt_r;

  // State register.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: fixed four-step sequence, run only gates leaving FETCH.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (run) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: state_next_s = S_EXEC;
      S_EXEC:   state_next_s = S_WB;
      S_WB:     state_next_s = S_FETCH;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Combinational decode of the latched instruction.
  always_comb begin
    dec_s = decode_instr(ir_r);
  end

  // Instruction register: loaded only on the FETCH edge that starts a new
  // instruction.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ir_r <= 32'h0000_0000;
    end else if ((state_r == S_FETCH) && run) begin
      ir_r <= instr;
    end
  end

  // Decoded outputs are captured once at the end of DECODE and then held,
  // including through the following FETCH.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rs_addr_r     <= 5'd0;
      rt_addr_r     <= 5'd0;
      wb_addr_r     <= 5'd0;
      shamt_r       <= 5'd0;
      imm_ext_r     <= 32'h0000_0000;
      alu_op_r      <= 4'd0;
      alu_src_imm_r <= 1'b0;
      legal_r       <= 1'b0;
    end else if (state_r == S_DECODE) begin
      rs_addr_r     <= ir_r[25:21];
      rt_addr_r     <= ir_r[20:16];
      wb_addr_r     <= dec_s.wb_addr;
      shamt_r       <= ir_r[10:6];
      imm_ext_r     <= dec_s.imm_ext;
      alu_op_r      <= dec_s.alu_op;
      alu_src_imm_r <= dec_s.alu_src_imm;
      legal_r       <= dec_s.legal;
    end
  end

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      illegal_r <= 1'b0;
    end else if ((state_r == S_DECODE) && !dec_s.legal) begin
      illegal_r <= 1'b1;
    end
  end

  // Strobes are registered one state early so they are high for exactly the
  // DECODE (pc_en) and WB (reg_we) cycles. Writes to $0 are suppressed.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      pc_en_r  <= 1'b0;
      reg_we_r <= 1'b0;
    end else begin
      pc_en_r  <= (state_r == S_FETCH) && run;
      reg_we_r <= (state_r == S_EXEC) && legal_r && (wb_addr_r != 5'd0);
    end
  end

  // Retired-instruction counter; every instruction retires, legal or not,
  // and the counter wraps naturally.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      instr_cnt_r <= 32'h0000_0000;
    end else if (state_r == S_WB) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end
  end

  assign ir          = ir_r;
  assign state       = state_r;
  assign rs_addr     = rs_addr_r;
  assign rt_addr     = rt_addr_r;
  assign wb_addr     = wb_addr_r;
  assign shamt       = shamt_r;
  assign imm_ext     = imm_ext_r;
  assign alu_op      = alu_op_r;
  assign alu_src_imm = alu_src_imm_r;
  assign reg_we      = reg_we_r;
  assign pc_en       = pc_en_r;
  assign illegal     = illegal_r;
  assign instr_cnt   = instr_cnt_r;

endmodule

// File: tb/tb_ri_control_unit.sv
// Testbench for ri_control_unit: table of instruction vectors with expected
// decode results pushed to a scoreboard queue when driven and popped in EXEC,
// plus hand-written sequences for reset, run control and mid-WB reset.
module tb_ri_control_unit;

  logic        clka;
  logic        rsta;
  logic        run;
  logic [31:0] instr;
  logic [31:0] ir;
  logic [1:0]  state;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wb_addr;
  logic [4:0]  shamt;
  logic [31:0] imm_ext;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_we;
  logic        pc_en;
  logic        illegal;
  logic [31:0] instr_cnt;

  ri_control_unit dut (
    .clka        (clka),
    .rsta        (rsta),
    .run         (run),
    .instr       (instr),
    .ir          (ir),
    .state       (state),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wb_addr     (wb_addr),
    .shamt       (shamt),
    .imm_ext     (imm_ext),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_we      (reg_we),
    .pc_en       (pc_en),
    .illegal     (illegal),
    .instr_cnt   (instr_cnt)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct {
    logic [31:0] w;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wb;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src;
    logic        we;
    logic        ill;
  } vec_t;

  int          tests;
  int          fails;
  logic [31:0] model_cnt;
  logic        model_ill;
  vec_t        sb_q[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] wb, input logic [4:0] sh, input logic [31:0] imm,
                              input logic [3:0] op, input logic src, input logic we, input logic ill);
    vec_t v;
    v.w = w; v.rs = rs; v.rt = rt; v.wb = wb; v.sh = sh;
    v.imm = imm; v.op = op; v.src = src; v.we = we; v.ill = ill;
    return v;
  endfunction

  // Runs one instruction through all four states, starting just after an
  // edge with the FSM in FETCH.
  task automatic exec_instr(input vec_t v);
    vec_t e;
    e = v;
    instr = v.w;
    run   = 1'b1;
    check("fetch_state", {30'd0, state}, 32'd0);
    sb_q.push_back(v);
    @(posedge clka); #1;
    check("decode_state", {30'd0, state}, 32'd1);
    check("decode_pc_en", {31'd0, pc_en}, 32'd1);
    check("decode_reg_we", {31'd0, reg_we}, 32'd0);
    check("decode_ir", ir, v.w);
    @(posedge clka); #1;
    check("exec_state", {30'd0, state}, 32'd2);
    check("exec_pc_en", {31'd0, pc_en}, 32'd0);
    check("exec_reg_we", {31'd0, reg_we}, 32'd0);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
    end
    check("rs_addr", {27'd0, rs_addr}, {27'd0, e.rs});
    check("rt_addr", {27'd0, rt_addr}, {27'd0, e.rt});
    check("wb_addr", {27'd0, wb_addr}, {27'd0, e.wb});
    check("shamt", {27'd0, shamt}, {27'd0, e.sh});
    check("imm_ext", imm_ext, e.imm);
    check("alu_op", {28'd0, alu_op}, {28'd0, e.op});
    check("alu_src_imm", {31'd0, alu_src_imm}, {31'd0, e.src});
    model_ill = model_ill | e.ill;
    check("exec_illegal", {31'd0, illegal}, {31'd0, model_ill});
    @(posedge clka); #1;
    check("wb_state", {30'd0, state}, 32'd3);
    check("wb_reg_we", {31'd0, reg_we}, {31'd0, e.we});
    check("wb_pc_en", {31'd0, pc_en}, 32'd0);
    @(posedge clka); #1;
    model_cnt = model_cnt + 32'd1;
    check("post_state", {30'd0, state}, 32'd0);
    check("post_reg_we", {31'd0, reg_we}, 32'd0);
    check("instr_cnt", instr_cnt, model_cnt);
    check("post_illegal", {31'd0, illegal}, {31'd0, model_ill});
    check("held_alu_op", {28'd0, alu_op}, {28'd0, e.op});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t add_v;
    tests     = 0;
    fails     = 0;
    model_cnt = 32'd0;
    model_ill = 1'b0;

    //          word          rs     rt     wb     sh     imm            op    src   we    ill
    add_v = mk(32'h012A4020, 5'd9, 5'd10, 5'd8, 5'd0, 32'h0000_0000, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs.push_back(add_v);
    vecs.push_back(mk(32'h3528FFFF, 5'd9, 5'd8,  5'd8, 5'd31, 32'h0000_FFFF, 4'd3, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h2128FFFF, 5'd9, 5'd8,  5'd8, 5'd31, 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h3C081234, 5'd0, 5'd8,  5'd8, 5'd8,  32'h1234_0000, 4'd9, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h2928FFFE, 5'd9, 5'd8,  5'd8, 5'd31, 32'hFFFF_FFFE, 4'd6, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h31288000, 5'd9, 5'd8,  5'd8, 5'd0,  32'h0000_8000, 4'd2, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h392800FF, 5'd9, 5'd8,  5'd8, 5'd3,  32'h0000_00FF, 4'd4, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h012A4022, 5'd9, 5'd10, 5'd8, 5'd0,  32'h0000_0000, 4'd1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h012A4027, 5'd9, 5'd10, 5'd8, 5'd0,  32'h0000_0000, 4'd5, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h000A4082, 5'd0, 5'd10, 5'd8, 5'd2,  32'h0000_0000, 4'd8, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h00000000, 5'd0, 5'd0,  5'd0, 5'd0,  32'h0000_0000, 4'd7, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h21200005, 5'd9, 5'd0,  5'd0, 5'd0,  32'h0000_0005, 4'd0, 1'b1, 1'b0, 1'b0));
    // lw is unsupported; the following add still runs, illegal stays set.
    vecs.push_back(mk(32'h8D280000, 5'd9, 5'd8,  5'd8, 5'd0,  32'h0000_0000, 4'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(add_v);
    // addu funct is unsupported in this subset.
    vecs.push_back(mk(32'h012A4021, 5'd9, 5'd10, 5'd8, 5'd0,  32'h0000_0000, 4'd0, 1'b0, 1'b0, 1'b1));

    // Reset with random instruction, release with run low.
    rsta  = 1'b1;
    run   = 1'b0;
    instr = $urandom;
    repeat (3) @(posedge clka);
    #1;
    rsta = 1'b0;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_imm_ext", imm_ext, 32'd0);
    check("rst_decoded", {rs_addr, rt_addr, wb_addr, shamt, alu_op, alu_src_imm}, 32'd0);
    check("rst_strobes", {29'd0, reg_we, pc_en, illegal}, 32'd0);
    check("rst_instr_cnt", instr_cnt, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clka); #1;
      check("idle_state", {30'd0, state}, 32'd0);
      check("idle_ir", ir, 32'd0);
      check("idle_pc_en", {31'd0, pc_en}, 32'd0);
    end

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      exec_instr(vecs[i]);
    end

    // run dropped during EXEC: instruction completes, then FSM parks.
    instr = 32'h012A4020;
    run   = 1'b1;
    @(posedge clka); #1;
    @(posedge clka); #1;
    run = 1'b0;
    check("rd_exec_state", {30'd0, state}, 32'd2);
    @(posedge clka); #1;
    check("rd_wb_state", {30'd0, state}, 32'd3);
    check("rd_wb_reg_we", {31'd0, reg_we}, 32'd1);
    @(posedge clka); #1;
    model_cnt = model_cnt + 32'd1;
    check("rd_cnt", instr_cnt, model_cnt);
    instr = 32'h3528FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clka); #1;
      check("rd_hold_state", {30'd0, state}, 32'd0);
      check("rd_hold_ir", ir, 32'h012A4020);
      check("rd_hold_pc_en", {31'd0, pc_en}, 32'd0);
    end
    exec_instr(vecs[1]);

    // Asynchronous reset in WB while reg_we is high.
    instr = 32'h012A4020;
    run   = 1'b1;
    repeat (3) begin
      @(posedge clka); #1;
    end
    check("mr_wb_state", {30'd0, state}, 32'd3);
    check("mr_wb_reg_we", {31'd0, reg_we}, 32'd1);
    #3;
    rsta = 1'b1;
    #1;
    check("mr_reg_we", {31'd0, reg_we}, 32'd0);
    check("mr_state", {30'd0, state}, 32'd0);
    check("mr_cnt", instr_cnt, 32'd0);
    check("mr_illegal", {31'd0, illegal}, 32'd0);
    check("mr_ir", ir, 32'd0);
    @(posedge clka); #1;
    rsta      = 1'b0;
    model_cnt = 32'd0;
    model_ill = 1'b0;
    // First edge after release with run high latches instr.
    exec_instr(vecs[3]);
    exec_instr(add_v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
